// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect/hazard inputs and the IF/ID register outputs.
// master = fetch stage, slave = memory / pipeline environment.
interface fetch_stage_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              stall;
    logic              imm_next;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              int_req;
    logic [15:0]       if_id_instruction;
    logic [ADDR_W-1:0] if_id_pc;
    logic              if_id_valid;
    logic              if_id_interrupt;

    modport master (
        input  imem_data, stall, imm_next, branch_taken, branch_target, int_req,
        output imem_addr, if_id_instruction, if_id_pc, if_id_valid, if_id_interrupt
    );

    modport slave (
        output imem_data, stall, imm_next, branch_taken, branch_target, int_req,
        input  imem_addr, if_id_instruction, if_id_pc, if_id_valid, if_id_interrupt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: reset/interrupt vector loading, branch redirect,
// and injection of the one-cycle interrupt marker consumed by decode.
module fetch_stage #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned RESET_VEC_ADDR = 0,
    parameter int unsigned INT_VEC_ADDR   = 1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StIntVec
    } stateE;

    localparam logic [15:0] Nop = 16'h0000;

    stateE             stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic              intPendingQ, intPendingD;
    logic [15:0]       instrQ, instrD;
    logic [ADDR_W-1:0] idPcQ, idPcD;
    logic              validQ, validD;
    logic              intMarkQ, intMarkD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ      <= StBoot;
            pcQ         <= '0;
            intPendingQ <= 1'b0;
            instrQ      <= Nop;
            idPcQ       <= '0;
            validQ      <= 1'b0;
            intMarkQ    <= 1'b0;
        end else begin
            stateQ      <= stateD;
            pcQ         <= pcD;
            intPendingQ <= intPendingD;
            instrQ      <= instrD;
            idPcQ       <= idPcD;
            validQ      <= validD;
            intMarkQ    <= intMarkD;
        end
    end

    always_comb begin
        case (stateQ)
            StBoot:   bus.imem_addr = ADDR_W'(RESET_VEC_ADDR);
            StIntVec: bus.imem_addr = ADDR_W'(INT_VEC_ADDR);
            default:  bus.imem_addr = pcQ;
        endcase
    end

    always_comb begin
        stateD      = stateQ;
        pcD         = pcQ;
        intPendingD = intPendingQ | bus.int_req;
        instrD      = instrQ;
        idPcD       = idPcQ;
        validD      = validQ;
        intMarkD    = intMarkQ;

        if (bus.branch_taken) begin
            pcD      = bus.branch_target;
            instrD   = Nop;
            validD   = 1'b0;
            intMarkD = 1'b0;
            stateD   = StRun;
            // A branch that cancels the vector load must not lose the interrupt.
            if (stateQ == StIntVec) begin
                intPendingD = 1'b1;
            end
        end else if (!bus.stall) begin
            unique case (stateQ)
                StBoot, StIntVec: begin
                    pcD      = ADDR_W'(bus.imem_data);
                    instrD   = Nop;
                    validD   = 1'b0;
                    intMarkD = 1'b0;
                    stateD   = StRun;
                end
                StRun: begin
                    // Never split an instruction from its immediate word.
                    if (intPendingQ && !bus.imm_next) begin
                        instrD      = Nop;
                        validD      = 1'b0;
                        intMarkD    = 1'b1;
                        idPcD       = pcQ;
                        intPendingD = bus.int_req;
                        stateD      = StIntVec;
                    end else begin
                        instrD   = bus.imem_data;
                        validD   = 1'b1;
                        intMarkD = 1'b0;
                        idPcD    = pcQ + ADDR_W'(1);
                        pcD      = pcQ + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.if_id_instruction = instrQ;
    assign bus.if_id_pc          = idPcQ;
    assign bus.if_id_valid       = validQ;
    assign bus.if_id_interrupt   = intMarkQ;

endmodule
